// File: rtl/fn_equiv_sequencer_if.sv
// fn_equiv_sequencer_if: control, vector and status signals between the sequencer and its surroundings
interface fn_equiv_sequencer_if;
  logic start, abort;
  logic vec_a, vec_b, vec_c;
  logic y_sop, y_pos, y_mk;
  logic busy, done, pass, fail_valid;
  logic [2:0] err_mask, fail_vec;
  modport master(output start, abort, y_sop, y_pos, y_mk,
                 input vec_a, vec_b, vec_c, busy, done, pass, err_mask, fail_valid, fail_vec);
  modport slave(input start, abort, y_sop, y_pos, y_mk,
                output vec_a, vec_b, vec_c, busy, done, pass, err_mask, fail_valid, fail_vec);
endinterface

// File: rtl/fn_equiv_sequencer.sv
// fn_equiv_sequencer: sweeps all 8 vectors through three implementations of Y=A&(~B|C) and checks them
module fn_equiv_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES = 1
) (
  input logic clk,
  input logic reset,
  fn_equiv_sequencer_if.slave bus
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW = PASSES > 1 ? $clog2(PASSES) : 1;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] idx, err_mask, fail_vec, miss;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sweep;
  logic pass, fail_valid, gold, run, last;
  assign run = state == APPLY || state == SETTLE || state == SAMPLE;
  assign gold = idx[2] & (~idx[1] | idx[0]);
  assign miss = {bus.y_sop, bus.y_pos, bus.y_mk} ^ {3{gold}};
  assign last = idx == 3'd7 && sweep == SW'(PASSES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? APPLY : IDLE;
      APPLY:   state_nx = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      SETTLE:  state_nx = cnt == '0 ? SAMPLE : SETTLE;
      SAMPLE:  state_nx = last ? DONE : APPLY;
      default: state_nx = IDLE;
    endcase
    if (run && bus.abort) state_nx = IDLE;
  end
  // an aborted SAMPLE records nothing and does not advance the vector
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      sweep <= '0;
      cnt <= '0;
      err_mask <= '0;
      fail_valid <= 1'b0;
      fail_vec <= '0;
      pass <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        idx <= '0;
        sweep <= '0;
        err_mask <= '0;
        fail_valid <= 1'b0;
        fail_vec <= '0;
        pass <= 1'b0;
      end
      if (state == APPLY) cnt <= CW'(SETTLE_CYCLES - 1);
      if (state == SETTLE) cnt <= cnt - 1'b1;
      if (state == SAMPLE && !bus.abort) begin
        err_mask <= err_mask | miss;
        if (!fail_valid && |miss) begin
          fail_valid <= 1'b1;
          fail_vec <= idx;
        end
        idx <= idx + 1'b1;
        if (idx == 3'd7) sweep <= sweep + 1'b1;
      end
      if (state == DONE) pass <= err_mask == '0;
    end
  assign {bus.vec_a, bus.vec_b, bus.vec_c} = idx;
  assign bus.busy = run;
  assign bus.done = state == DONE;
  assign bus.pass = pass;
  assign bus.err_mask = err_mask;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec = fail_vec;
endmodule

// File: tb/tb_fn_equiv_sequencer.sv
// tb_fn_equiv_sequencer: scoreboard bench for the equivalence sequencer (two parameterisations)
module tb_fn_equiv_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, sel = 1'b0;
  logic pos_stuck = 1'b0, mk_bad = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  fn_equiv_sequencer_if ia();
  fn_equiv_sequencer_if ib();
  fn_equiv_sequencer #(.SETTLE_CYCLES(1), .PASSES(1)) dut_a(.clk(clk), .reset(reset), .bus(ia.slave));
  fn_equiv_sequencer #(.SETTLE_CYCLES(0), .PASSES(2)) dut_b(.clk(clk), .reset(reset), .bus(ib.slave));
  function automatic logic g(input logic [2:0] v);
    return v[2] & (~v[1] | v[0]);
  endfunction
  logic [2:0] va, vb;
  assign va = {ia.vec_a, ia.vec_b, ia.vec_c};
  assign vb = {ib.vec_a, ib.vec_b, ib.vec_c};
  assign ia.y_sop = g(va);
  assign ia.y_pos = pos_stuck ? 1'b1 : g(va);
  assign ia.y_mk = g(va) ^ (mk_bad && va == 3'b110);
  assign ib.y_sop = g(vb);
  assign ib.y_pos = g(vb);
  assign ib.y_mk = g(vb);
  assign ia.start = start & ~sel;
  assign ib.start = start & sel;
  assign ia.abort = abort & ~sel;
  assign ib.abort = abort & sel;
  logic c_busy, c_done, c_pass, c_fvalid;
  logic [2:0] c_err, c_fvec, c_vec;
  assign c_busy = sel ? ib.busy : ia.busy;
  assign c_done = sel ? ib.done : ia.done;
  assign c_pass = sel ? ib.pass : ia.pass;
  assign c_fvalid = sel ? ib.fail_valid : ia.fail_valid;
  assign c_err = sel ? ib.err_mask : ia.err_mask;
  assign c_fvec = sel ? ib.fail_vec : ia.fail_vec;
  assign c_vec = sel ? vb : va;
  typedef struct packed {logic [2:0] err; logic fvalid; logic [2:0] fvec; logic pass;} res_t;
  res_t res_q[$];
  logic [2:0] vec_q[$];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int exp_busy, input int passes, input res_t exp, input int restart_at, input int abort_at);
    int n;
    logic [2:0] prev, ev;
    res_t r;
    for (int p = 0; p < passes; p++)
      for (int v = 0; v < 8; v++) vec_q.push_back(3'(v));
    res_q.push_back(exp);
    prev = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (c_busy && n < 500) begin
      if (n == 0 || c_vec != prev) begin
        checks++;
        if (vec_q.size() == 0) begin
          errors++;
          $display("FAIL vec_extra: got vector %b with none expected at busy cycle %0d", c_vec, n);
        end else begin
          ev = vec_q.pop_front();
          if (c_vec !== ev) begin
            errors++;
            $display("FAIL vec_seq: got %b want %b at busy cycle %0d", c_vec, ev, n);
          end
        end
      end
      prev = c_vec;
      start = n == restart_at;
      abort = n == abort_at;
      step();
      start = 1'b0;
      abort = 1'b0;
      n++;
    end
    r = res_q.pop_front();
    checks++;
    if (n !== exp_busy) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles want %0d", n, exp_busy);
    end
    if (abort_at >= 0) begin
      vec_q.delete();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (c_done !== 1'b0 || c_busy !== 1'b0 || c_pass !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle: got done=%b busy=%b pass=%b want 0 0 0", c_done, c_busy, c_pass);
        end
        step();
      end
      checks++;
      if ({c_err, c_fvalid} !== {r.err, r.fvalid}) begin
        errors++;
        $display("FAIL abort_keep: got err=%b fvalid=%b want err=%b fvalid=%b", c_err, c_fvalid, r.err, r.fvalid);
      end
      return;
    end
    checks++;
    if (c_done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got %b want 1", c_done);
    end
    checks++;
    if (vec_q.size() != 0) begin
      errors++;
      $display("FAIL vec_count: got %0d vectors unseen want 0", vec_q.size());
      vec_q.delete();
    end
    checks++;
    if (c_err !== r.err || c_fvalid !== r.fvalid) begin
      errors++;
      $display("FAIL err_flags: got err=%b fvalid=%b want err=%b fvalid=%b", c_err, c_fvalid, r.err, r.fvalid);
    end
    if (r.fvalid) begin
      checks++;
      if (c_fvec !== r.fvec) begin
        errors++;
        $display("FAIL fail_vec: got %b want %b", c_fvec, r.fvec);
      end
    end
    step();
    checks++;
    if (c_done !== 1'b0 || c_busy !== 1'b0 || c_pass !== r.pass) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b pass=%b want 0 0 %b", c_done, c_busy, c_pass, r.pass);
    end
  endtask
  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({ia.busy, ia.done, ia.pass, ia.err_mask, ia.fail_valid, ia.fail_vec, va} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b pass=%b err=%b fv=%b fvec=%b vec=%b want all 0",
               ia.busy, ia.done, ia.pass, ia.err_mask, ia.fail_valid, ia.fail_vec, va);
    end
    reset = 1'b0;
    step();
  endtask
  task automatic test_correct();
    run(24, 1, '{err: 3'b000, fvalid: 1'b0, fvec: 3'b000, pass: 1'b1}, -1, -1);
  endtask
  task automatic test_pos_stuck();
    pos_stuck = 1'b1;
    run(24, 1, '{err: 3'b010, fvalid: 1'b1, fvec: 3'b000, pass: 1'b0}, -1, -1);
    pos_stuck = 1'b0;
  endtask
  task automatic test_mk_fault();
    mk_bad = 1'b1;
    run(24, 1, '{err: 3'b001, fvalid: 1'b1, fvec: 3'b110, pass: 1'b0}, -1, -1);
    mk_bad = 1'b0;
  endtask
  task automatic test_abort();
    run(11, 1, '{err: 3'b000, fvalid: 1'b0, fvec: 3'b000, pass: 1'b0}, -1, 10);
    run(24, 1, '{err: 3'b000, fvalid: 1'b0, fvec: 3'b000, pass: 1'b1}, -1, -1);
  endtask
  task automatic test_restart_ignored();
    mk_bad = 1'b1;
    run(24, 1, '{err: 3'b001, fvalid: 1'b1, fvec: 3'b110, pass: 1'b0}, 5, -1);
    mk_bad = 1'b0;
  endtask
  task automatic test_async_reset();
    pos_stuck = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    checks++;
    if (ia.err_mask !== 3'b010 || ia.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_state: got err=%b busy=%b want 010 1", ia.err_mask, ia.busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ia.busy, ia.done, ia.pass, ia.err_mask, ia.fail_valid, ia.fail_vec, va} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b pass=%b err=%b fv=%b fvec=%b vec=%b want all 0",
               ia.busy, ia.done, ia.pass, ia.err_mask, ia.fail_valid, ia.fail_vec, va);
    end
    step();
    reset = 1'b0;
    pos_stuck = 1'b0;
    repeat (3) step();
    checks++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", ia.busy, ia.done);
    end
    run(24, 1, '{err: 3'b000, fvalid: 1'b0, fvec: 3'b000, pass: 1'b1}, -1, -1);
  endtask
  task automatic test_two_pass();
    sel = 1'b1;
    run(32, 2, '{err: 3'b000, fvalid: 1'b0, fvec: 3'b000, pass: 1'b1}, -1, -1);
    sel = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_correct();
    test_pos_stuck();
    test_mk_fault();
    test_abort();
    test_restart_ignored();
    test_async_reset();
    test_two_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
